// File: rtl/frame_buf_mgr.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_mgr
// Description : N-buffer frame store manager between the SDRAM frame writer
//               and the VGA read path. Grants the writer a free buffer,
//               hands the reader the newest completed frame on every frame
//               sync, and counts dropped and repeated frames.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buf_mgr #(
    parameter int NUM_BUF    = 3,
    parameter int ADDR_W     = 24,
    parameter int BUF_STRIDE = 1048576,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              steal_en,
    input  logic              wr_start,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] wr_base,
    output logic              wr_busy,
    input  logic              wr_done,
    input  logic              rd_sync,
    output logic [ADDR_W-1:0] rd_base,
    output logic              rd_valid,
    output logic              rd_new,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  repeat_cnt
);

    localparam int         c_IDX_W   = $clog2(NUM_BUF);
    localparam logic [1:0] c_FREE    = 2'd0;
    localparam logic [1:0] c_WRITING = 2'd1;
    localparam logic [1:0] c_READY   = 2'd2;
    localparam logic [1:0] c_READING = 2'd3;

    logic [1:0]         r_state [NUM_BUF];
    logic [1:0]         w_state_nx [NUM_BUF];
    logic               r_pending, r_wr_ack, r_wr_busy, r_rd_valid, r_rd_new;
    logic [ADDR_W-1:0]  r_wr_base, r_rd_base;
    logic [CNT_W-1:0]   r_drop, r_repeat;

    logic               w_has_wr, w_has_rdy, w_has_free, w_sync_has;
    logic [c_IDX_W-1:0] w_wr_idx, w_rdy_idx, w_free_idx, w_sync_idx, w_gnt_idx;
    logic               w_start_ok, w_req, w_grant, w_drop_inc, w_repeat_inc;
    logic               w_busy_nx;

    // Buffer base address, truncated to the SDRAM address width.
    function automatic logic [ADDR_W-1:0] base_of(input logic [c_IDX_W-1:0] idx);
        return ADDR_W'(64'(idx) * 64'(BUF_STRIDE));
    endfunction

    // Next buffer states: writer completion first, then the frame sync on the
    // post-completion view, then the grant decided from the registered state
    // so a buffer freed by a sync is only grantable one cycle later.
    always_comb begin
        w_state_nx   = r_state;
        w_has_wr     = 1'b0;  w_wr_idx   = '0;
        w_has_rdy    = 1'b0;  w_rdy_idx  = '0;
        w_has_free   = 1'b0;  w_free_idx = '0;
        w_sync_has   = 1'b0;  w_sync_idx = '0;
        w_grant      = 1'b0;  w_gnt_idx  = '0;
        w_drop_inc   = 1'b0;
        w_repeat_inc = 1'b0;
        w_busy_nx    = 1'b0;

        // descending scan so the lowest FREE index wins
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (r_state[i] == c_WRITING) begin w_has_wr   = 1'b1; w_wr_idx   = c_IDX_W'(i); end
            if (r_state[i] == c_READY)   begin w_has_rdy  = 1'b1; w_rdy_idx  = c_IDX_W'(i); end
            if (r_state[i] == c_FREE)    begin w_has_free = 1'b1; w_free_idx = c_IDX_W'(i); end
        end

        // completed frame supersedes any unread READY frame
        if (wr_done && w_has_wr) begin
            w_state_nx[w_wr_idx] = c_READY;
            if (w_has_rdy) begin
                w_state_nx[w_rdy_idx] = c_FREE;
                w_drop_inc            = 1'b1;
            end
        end

        for (int i = 0; i < NUM_BUF; i++) begin
            if (w_state_nx[i] == c_READY) begin w_sync_has = 1'b1; w_sync_idx = c_IDX_W'(i); end
        end

        if (rd_sync) begin
            if (w_sync_has) begin
                for (int i = 0; i < NUM_BUF; i++) begin
                    if (w_state_nx[i] == c_READING) w_state_nx[i] = c_FREE;
                end
                w_state_nx[w_sync_idx] = c_READING;
            end else if (r_rd_valid) begin
                w_repeat_inc = 1'b1;
            end
        end

        // a start in the same cycle as done is accepted because done clears busy
        w_start_ok = wr_start && (!w_has_wr || wr_done);
        w_req      = r_pending || w_start_ok;

        // granting only with nothing WRITING keeps steal and drop exclusive;
        // stealing is held off while a sync is moving the READY buffer
        if (w_req && !w_has_wr) begin
            if (w_has_free) begin
                w_grant   = 1'b1;
                w_gnt_idx = w_free_idx;
                w_state_nx[w_free_idx] = c_WRITING;
            end else if (steal_en && w_has_rdy && !rd_sync) begin
                w_grant    = 1'b1;
                w_gnt_idx  = w_rdy_idx;
                w_drop_inc = 1'b1;
                w_state_nx[w_rdy_idx] = c_WRITING;
            end
        end

        for (int i = 0; i < NUM_BUF; i++) begin
            if (w_state_nx[i] == c_WRITING) w_busy_nx = 1'b1;
        end
    end

    // Register buffer states, handshake outputs and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BUF; i++) r_state[i] <= c_FREE;
            r_pending  <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_wr_base  <= '0;
            r_wr_busy  <= 1'b0;
            r_rd_base  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_new   <= 1'b0;
            r_drop     <= '0;
            r_repeat   <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_pending <= w_req && !w_grant;
            r_wr_ack  <= w_grant;
            r_wr_busy <= w_busy_nx;
            r_rd_new  <= rd_sync && w_sync_has;
            if (w_grant) r_wr_base <= base_of(w_gnt_idx);
            if (rd_sync && w_sync_has) begin
                r_rd_base  <= base_of(w_sync_idx);
                r_rd_valid <= 1'b1;
            end
            if (w_drop_inc && (r_drop != '1))     r_drop   <= r_drop + 1'b1;
            if (w_repeat_inc && (r_repeat != '1)) r_repeat <= r_repeat + 1'b1;
        end
    end

    assign wr_ack     = r_wr_ack;
    assign wr_base    = r_wr_base;
    assign wr_busy    = r_wr_busy;
    assign rd_base    = r_rd_base;
    assign rd_valid   = r_rd_valid;
    assign rd_new     = r_rd_new;
    assign drop_cnt   = r_drop;
    assign repeat_cnt = r_repeat;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_mgr.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buf_mgr
// Description : Directed bench for frame_buf_mgr; a 3-buffer instance covers
//               grants, drops, repeats and reset, a 2-buffer instance covers
//               wait-for-sync versus steal.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buf_mgr;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_vec = 0;
    int          n_err = 0;

    // 3-buffer instance
    logic        a_steal, a_start, a_done, a_sync;
    logic        a_ack, a_busy, a_valid, a_new;
    logic [23:0] a_wbase, a_rbase;
    logic [15:0] a_drop, a_rep;

    // 2-buffer instance
    logic        b_steal, b_start, b_done, b_sync;
    logic        b_ack, b_busy, b_valid, b_new;
    logic [23:0] b_wbase, b_rbase;
    logic [15:0] b_drop, b_rep;

    logic [23:0] exp_base, prev_base;

    always #5 clk = ~clk;

    frame_buf_mgr #(.NUM_BUF(3), .ADDR_W(24), .BUF_STRIDE(1048576), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .steal_en(a_steal), .wr_start(a_start),
        .wr_ack(a_ack), .wr_base(a_wbase), .wr_busy(a_busy), .wr_done(a_done),
        .rd_sync(a_sync), .rd_base(a_rbase), .rd_valid(a_valid), .rd_new(a_new),
        .drop_cnt(a_drop), .repeat_cnt(a_rep)
    );

    frame_buf_mgr #(.NUM_BUF(2), .ADDR_W(24), .BUF_STRIDE(1048576), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .steal_en(b_steal), .wr_start(b_start),
        .wr_ack(b_ack), .wr_base(b_wbase), .wr_busy(b_busy), .wr_done(b_done),
        .rd_sync(b_sync), .rd_base(b_rbase), .rd_valid(b_valid), .rd_new(b_new),
        .drop_cnt(b_drop), .repeat_cnt(b_rep)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        {a_steal, a_start, a_done, a_sync} = '0;
        {b_steal, b_start, b_done, b_sync} = '0;
        #2;
        chk("rst_ack",   a_ack,   0);
        chk("rst_wbase", a_wbase, 0);
        chk("rst_busy",  a_busy,  0);
        chk("rst_rbase", a_rbase, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_new",   a_new,   0);
        chk("rst_drop",  a_drop,  0);
        chk("rst_rep",   a_rep,   0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // done with nothing writing and sync before any frame: no effect
        a_done = 1; tick(); a_done = 0;
        chk("idle_done_busy", a_busy, 0);
        chk("idle_done_drop", a_drop, 0);
        a_sync = 1; tick(); a_sync = 0;
        chk("early_sync_valid", a_valid, 0);
        chk("early_sync_rbase", a_rbase, 0);
        chk("early_sync_rep",   a_rep,   0);
        chk("early_sync_new",   a_new,   0);

        // first frame
        a_start = 1; tick(); a_start = 0;
        chk("first_ack",   a_ack,   1);
        chk("first_wbase", a_wbase, 24'h000000);
        chk("first_busy",  a_busy,  1);
        tick();
        chk("first_ack_pulse", a_ack, 0);
        a_done = 1; tick(); a_done = 0;
        chk("first_done_busy", a_busy, 0);
        a_sync = 1; tick(); a_sync = 0;
        chk("first_rbase", a_rbase, 24'h000000);
        chk("first_valid", a_valid, 1);
        chk("first_new",   a_new,   1);
        tick();
        chk("first_new_pulse", a_new, 0);

        // steady state: next write starts before the sync that shows the last one
        prev_base = '0;
        for (int k = 0; k < 9; k++) begin
            exp_base = 24'(((k + 1) % 3) * 24'h100000);
            a_start = 1; tick(); a_start = 0;
            chk("steady_ack",   a_ack,   1);
            chk("steady_wbase", a_wbase, exp_base);
            if (k > 0) begin
                a_sync = 1; tick(); a_sync = 0;
                chk("steady_rbase", a_rbase, prev_base);
                chk("steady_new",   a_new,   1);
            end
            a_done = 1; tick(); a_done = 0;
            prev_base = exp_base;
        end
        a_sync = 1; tick(); a_sync = 0;
        chk("steady_last_rbase", a_rbase, 24'h000000);
        chk("steady_drop", a_drop, 0);
        chk("steady_rep",  a_rep,  0);

        // writer twice as fast: second completed frame drops the first
        a_start = 1; tick(); a_start = 0;
        chk("fast_wbase1", a_wbase, 24'h100000);
        a_done = 1; tick(); a_done = 0;
        a_start = 1; tick(); a_start = 0;
        chk("fast_wbase2", a_wbase, 24'h200000);
        a_done = 1; tick(); a_done = 0;
        chk("fast_drop", a_drop, 1);
        a_sync = 1; tick(); a_sync = 0;
        chk("fast_rbase", a_rbase, 24'h200000);
        chk("fast_new",   a_new,   1);

        // reader faster: three syncs with nothing new
        for (int k = 0; k < 3; k++) begin
            a_sync = 1; tick(); a_sync = 0;
            chk("rep_new",   a_new,   0);
            chk("rep_rbase", a_rbase, 24'h200000);
        end
        chk("rep_cnt", a_rep, 3);

        // done and sync in the same cycle: frame shown at that sync
        a_start = 1; tick(); a_start = 0;
        chk("same_wbase", a_wbase, 24'h000000);
        a_done = 1; a_sync = 1; tick(); a_done = 0; a_sync = 0;
        chk("same_rbase", a_rbase, 24'h000000);
        chk("same_new",   a_new,   1);
        chk("same_rep",   a_rep,   3);
        chk("same_busy",  a_busy,  0);

        // start while busy is ignored
        a_start = 1; tick(); a_start = 0;
        chk("busy_wbase", a_wbase, 24'h100000);
        a_start = 1; tick(); a_start = 0;
        chk("busy_ignored_ack", a_ack, 0);
        a_done = 1; tick(); a_done = 0;
        chk("busy_done_ack", a_ack, 0);
        tick();
        chk("busy_no_pending", a_ack, 0);

        // reset in the middle of a write
        a_start = 1; tick(); a_start = 0;
        chk("pre_rst_wbase", a_wbase, 24'h200000);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  a_busy,  0);
        chk("mid_rst_wbase", a_wbase, 0);
        chk("mid_rst_rbase", a_rbase, 0);
        chk("mid_rst_valid", a_valid, 0);
        chk("mid_rst_drop",  a_drop,  0);
        chk("mid_rst_rep",   a_rep,   0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ack", a_ack, 0);

        // 2-buffer instance: reach READING + READY
        b_start = 1; tick(); b_start = 0;
        chk("b_wbase0", b_wbase, 24'h000000);
        b_done = 1; tick(); b_done = 0;
        b_sync = 1; tick(); b_sync = 0;
        chk("b_rbase0", b_rbase, 24'h000000);
        b_start = 1; tick(); b_start = 0;
        chk("b_wbase1", b_wbase, 24'h100000);
        b_done = 1; tick(); b_done = 0;

        // no steal: request waits for a sync
        b_start = 1; tick(); b_start = 0;
        chk("b_wait_ack1", b_ack, 0);
        tick();
        chk("b_wait_ack2", b_ack, 0);
        b_sync = 1; tick(); b_sync = 0;
        chk("b_sync_ack",   b_ack,   0);
        chk("b_sync_rbase", b_rbase, 24'h100000);
        tick();
        chk("b_late_ack",   b_ack,   1);
        chk("b_late_wbase", b_wbase, 24'h000000);
        chk("b_nosteal_drop", b_drop, 0);
        b_done = 1; tick(); b_done = 0;

        // steal: READY buffer reclaimed immediately
        b_steal = 1;
        b_start = 1; tick(); b_start = 0;
        chk("b_steal_ack",   b_ack,   1);
        chk("b_steal_wbase", b_wbase, 24'h000000);
        chk("b_steal_drop",  b_drop,  1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
